tis_stack_node: RTL and testbench

Parametrised LIFO storage node for the TIS-100 fabric. It is the stack-memory tile that sits beside compute nodes on the port mesh. Generalises the fixed 8-bit enable/reset registers to a WIDTH x DEPTH register array with push/pop valid-ready handshakes, occupancy flags, synchronous flush, and optional TIS-100 value saturation on write.

---
 rtl/tis_pkg.sv | 21 ++
 rtl/tis_stack_node_if.sv | 32 +++
 rtl/tis_sat_clamp.sv | 29 ++
 rtl/tis_stack_node.sv | 82 ++++++++
 tb/tb_tis_stack_node.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/tis_pkg.sv
// Shared TIS-100 fabric constants and types used by stack and compute nodes.
package tis_pkg;

  localparam int TIS_WORD_W      = 11;
  localparam int TIS_SAT_MAX     = 999;
  localparam int TIS_STACK_DEPTH = 15;

  // Count has to represent 0..DEPTH inclusive.
  localparam int TIS_STACK_CNT_W = $clog2(TIS_STACK_DEPTH + 1);

  typedef logic signed [TIS_WORD_W-1:0] tis_word_t;

  // Which transfers fire in a cycle, encoded as {push_fire, pop_fire}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } stack_op_e;

endpackage

// File: rtl/tis_stack_node_if.sv
// Push/pop handshake bundle of a TIS-100 stack node, plus flush and occupancy.
interface tis_stack_node_if
  import tis_pkg::*;
#(
  parameter int WIDTH = TIS_WORD_W,
  parameter int CNT_W = TIS_STACK_CNT_W
);

  logic                    clear;
  logic                    push_valid;
  logic                    push_ready;
  logic signed [WIDTH-1:0] push_data;
  logic                    pop_valid;
  logic                    pop_ready;
  logic signed [WIDTH-1:0] pop_data;
  logic [CNT_W-1:0]        count;
  logic                    full;
  logic                    empty;

  // Master: the mesh neighbour using the stack.
  modport master (
    output clear, push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, count, full, empty
  );

  // Slave: the stack node itself.
  modport slave (
    input  clear, push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, count, full, empty
  );

endinterface

// File: rtl/tis_sat_clamp.sv
// Combinational clamp of a signed word to [-SAT_MAX, +SAT_MAX]; pass-through when SAT_EN=0.
module tis_sat_clamp
  import tis_pkg::*;
#(
  parameter int WIDTH   = TIS_WORD_W,
  parameter int SAT_MAX = TIS_SAT_MAX,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic signed [WIDTH-1:0] data_in,
  output logic signed [WIDTH-1:0] data_out
);

  localparam logic signed [WIDTH-1:0] POS_LIM = WIDTH'(SAT_MAX);
  localparam logic signed [WIDTH-1:0] NEG_LIM = -POS_LIM;

  generate
    if (SAT_EN) begin : g_clamp
      // Both operands are signed at full WIDTH, so the compares are two's-complement.
      always_comb begin
        if (data_in > POS_LIM)      data_out = POS_LIM;
        else if (data_in < NEG_LIM) data_out = NEG_LIM;
        else                        data_out = data_in;
      end
    end else begin : g_pass
      assign data_out = data_in;
    end
  endgenerate

endmodule

// File: rtl/tis_stack_node.sv
// TIS-100 LIFO stack tile: WIDTH x DEPTH register array behind push/pop valid-ready ports.
module tis_stack_node
  import tis_pkg::*;
#(
  parameter int WIDTH   = TIS_WORD_W,
  parameter int DEPTH   = TIS_STACK_DEPTH,
  parameter int CNT_W   = TIS_STACK_CNT_W,
  parameter bit SAT_EN  = 1'b1,
  parameter int SAT_MAX = TIS_SAT_MAX
) (
  input logic              clk,
  input logic              reset,
  tis_stack_node_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic signed [WIDTH-1:0] mem [DEPTH];
  logic signed [WIDTH-1:0] sat_data;
  logic                    full_s;
  logic                    empty_s;
  logic                    push_fire;
  logic                    pop_fire;
  logic [AW-1:0]           top_idx;
  logic [AW-1:0]           wr_idx;
  stack_op_e               op;

  // Flags decode registered count only, so ready/valid never depend on the partner's strobe.
  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign empty_s   = (count_q == '0);
  assign push_fire = bus.push_valid & ~full_s;
  assign pop_fire  = bus.pop_ready & ~empty_s;
  assign op        = stack_op_e'({push_fire, pop_fire});

  assign top_idx = AW'(count_q - CNT_W'(1));
  // A swap overwrites the top being handed out; a plain push lands one above it.
  assign wr_idx  = pop_fire ? top_idx : AW'(count_q);

  tis_sat_clamp #(
    .WIDTH   (WIDTH),
    .SAT_MAX (SAT_MAX),
    .SAT_EN  (SAT_EN)
  ) u_sat (
    .data_in  (bus.push_data),
    .data_out (sat_data)
  );

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (bus.clear) begin
      count_d = '0;
    end else begin
      unique case (op)
        OP_PUSH: count_d = count_q + CNT_W'(1);
        OP_POP:  count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking in clocked blocks so every register samples pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // NOTE: the array has no reset; entries above count are never observed, so their contents are don't-care.
  always_ff @(posedge clk) begin
    if (push_fire && !bus.clear) mem[wr_idx] <= sat_data;
  end

  assign bus.pop_data   = empty_s ? '0 : mem[top_idx];
  assign bus.push_ready = ~full_s;
  assign bus.pop_valid  = ~empty_s;
  assign bus.count      = count_q;
  assign bus.full       = full_s;
  assign bus.empty      = empty_s;

endmodule

// File: tb/tb_tis_stack_node.sv
// Bench for tis_stack_node: saturating and non-saturating instances against a queue-based LIFO model.
module tb_tis_stack_node;
  import tis_pkg::*;

  localparam int W  = TIS_WORD_W;
  localparam int D  = TIS_STACK_DEPTH;
  localparam int CW = TIS_STACK_CNT_W;

  typedef int iq_t[$];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pv    = 1'b0;
  logic pr    = 1'b0;
  logic cl    = 1'b0;
  logic signed [W-1:0] pd = '0;

  int n_checks = 0;
  int n_errors = 0;

  iq_t qa, qb;

  tis_stack_node_if #(.WIDTH(W), .CNT_W(CW)) bus_a ();
  tis_stack_node_if #(.WIDTH(W), .CNT_W(CW)) bus_b ();

  assign bus_a.push_valid = pv;
  assign bus_a.push_data  = pd;
  assign bus_a.pop_ready  = pr;
  assign bus_a.clear      = cl;
  assign bus_b.push_valid = pv;
  assign bus_b.push_data  = pd;
  assign bus_b.pop_ready  = pr;
  assign bus_b.clear      = cl;

  tis_stack_node #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .SAT_EN(1'b1), .SAT_MAX(TIS_SAT_MAX))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  tis_stack_node #(.WIDTH(W), .DEPTH(D), .CNT_W(CW), .SAT_EN(1'b0), .SAT_MAX(TIS_SAT_MAX))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int x, bit en);
    if (!en)        return x;
    if (x > 999)    return 999;
    if (x < -999)   return -999;
    return x;
  endfunction

  // Model: the stack is a queue whose last element is the top.
  function automatic iq_t next_q(iq_t q, bit en);
    int n   = q.size();
    bit pf  = pv && (n < D);
    bit of  = pr && (n > 0);
    int val = int'(pd);
    if (cl)             q.delete();
    else if (pf && of)  q[n-1] = sat(val, en);
    else if (pf)        q.push_back(sat(val, en));
    else if (of)        void'(q.pop_back());
    return q;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      qa = next_q(qa, 1'b1);
      qb = next_q(qb, 1'b0);
    end
  end

  task automatic cmp(input string tag, input iq_t q, input logic [CW-1:0] cnt,
                     input logic signed [W-1:0] data, input logic f, input logic e,
                     input logic prdy, input logic pval);
    int n   = q.size();
    int top = (n > 0) ? q[n-1] : 0;
    check({tag, ".count"},      {28'd0, cnt}, n);
    check({tag, ".pop_data"},   data, top);
    check({tag, ".full"},       {31'd0, f},    (n == D) ? 1 : 0);
    check({tag, ".empty"},      {31'd0, e},    (n == 0) ? 1 : 0);
    check({tag, ".push_ready"}, {31'd0, prdy}, (n < D) ? 1 : 0);
    check({tag, ".pop_valid"},  {31'd0, pval}, (n > 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    cmp("a", qa, bus_a.count, bus_a.pop_data, bus_a.full, bus_a.empty, bus_a.push_ready, bus_a.pop_valid);
    cmp("b", qb, bus_b.count, bus_b.pop_data, bus_b.full, bus_b.empty, bus_b.push_ready, bus_b.pop_valid);
  end

  // Present one cycle of stimulus, let the edge take it, then return to idle just after the edge.
  task automatic drive(input bit v, input int d, input bit r, input bit c);
    pv = v;
    pd = W'(d);
    pr = r;
    cl = c;
    @(posedge clk);
    #1;
    pv = 1'b0;
    pr = 1'b0;
    cl = 1'b0;
  endtask

  task automatic push(input int d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop();
    drive(1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic flush();
    drive(1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    int push_pct;
    int d;
    logic signed [W-1:0] rnd;
    int picks[6] = '{999, 1000, -999, -1000, 1023, -1024};

    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset.count", {28'd0, bus_a.count}, 0);
    check("reset.empty", {31'd0, bus_a.empty}, 1);
    check("reset.pop_data", bus_a.pop_data, 0);

    // Asynchronous reset in the middle of a cycle clears without a clock edge.
    push(5);
    push(6);
    check("pre_areset.count", {28'd0, bus_a.count}, 2);
    #2 reset = 1'b1;
    #1;
    check("areset.count", {28'd0, bus_a.count}, 0);
    check("areset.empty", {31'd0, bus_a.empty}, 1);
    check("areset.push_ready", {31'd0, bus_a.push_ready}, 1);
    check("areset.pop_valid", {31'd0, bus_a.pop_valid}, 0);
    check("areset.pop_data", bus_a.pop_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LIFO order and count trace.
    push(5);    check("lifo.count1", {28'd0, bus_a.count}, 1);
    push(-7);   check("lifo.count2", {28'd0, bus_a.count}, 2);
    push(300);  check("lifo.count3", {28'd0, bus_a.count}, 3);
    check("lifo.pop1", bus_a.pop_data, 300);
    pop();      check("lifo.count4", {28'd0, bus_a.count}, 2);
    check("lifo.pop2", bus_a.pop_data, -7);
    pop();      check("lifo.count5", {28'd0, bus_a.count}, 1);
    check("lifo.pop3", bus_a.pop_data, 5);
    pop();      check("lifo.count6", {28'd0, bus_a.count}, 0);
    check("lifo.empty", {31'd0, bus_a.empty}, 1);
    check("lifo.pop_data0", bus_a.pop_data, 0);

    // Fill to DEPTH, stall a further push, then pop once.
    for (int i = 1; i <= D; i++) push(i);
    check("fill.full", {31'd0, bus_a.full}, 1);
    check("fill.push_ready", {31'd0, bus_a.push_ready}, 0);
    push(99);
    check("fill.stall_count", {28'd0, bus_a.count}, 15);
    check("fill.top", bus_a.pop_data, 15);
    pop();
    check("fill.push_ready_after", {31'd0, bus_a.push_ready}, 1);
    check("fill.count_after", {28'd0, bus_a.count}, 14);
    check("fill.next_top", bus_a.pop_data, 14);
    flush();

    // Simultaneous push and pop swaps the top.
    push(10);
    push(20);
    check("swap.reader_gets", bus_a.pop_data, 20);
    drive(1'b1, 42, 1'b1, 1'b0);
    check("swap.count", {28'd0, bus_a.count}, 2);
    check("swap.new_top", bus_a.pop_data, 42);
    pop();
    check("swap.bottom", bus_a.pop_data, 10);
    flush();

    // Saturation on the SAT_EN=1 instance only.
    push(1023);
    push(-1024);
    check("sat.a_top", bus_a.pop_data, -999);
    check("sat.b_top", bus_b.pop_data, -1024);
    pop();
    check("sat.a_next", bus_a.pop_data, 999);
    check("sat.b_next", bus_b.pop_data, 1023);
    flush();

    // Clear wins over a push in the same cycle.
    push(1);
    push(2);
    push(3);
    drive(1'b1, 77, 1'b0, 1'b1);
    check("clear.count", {28'd0, bus_a.count}, 0);
    check("clear.empty", {31'd0, bus_a.empty}, 1);
    check("clear.pop_data", bus_a.pop_data, 0);
    push(8);
    check("clear.after_push", bus_a.pop_data, 8);
    check("clear.after_count", {28'd0, bus_a.count}, 1);

    // Randomised traffic with phases that drift toward full and toward empty.
    push_pct = 80;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) push_pct = (push_pct == 80) ? 25 : 80;
      if (i == 1500) begin
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
      end
      case ($urandom_range(0, 3))
        0: begin rnd = W'($urandom); d = int'(rnd); end
        1: d = picks[$urandom_range(0, 5)];
        default: d = int'($urandom_range(0, 200)) - 100;
      endcase
      drive($urandom_range(0, 99) < push_pct, d,
            $urandom_range(0, 99) < (100 - push_pct),
            $urandom_range(0, 63) == 0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
